// File: rtl/wb_bus_timeout_if.sv
// Wishbone B3 classic bus bundle; the watchdog sits between a CPU-side link
// (watchdog is the slave) and an interconnect-side link (watchdog is the master).
interface wb_bus_timeout_if;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic [3:0]  sel;
    logic        we;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        cyc;
    logic        stb;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (
        output adr, dat_w, sel, we, cti, bte, cyc, stb,
        input  dat_r, ack, err, rty
    );

    modport slave (
        input  adr, dat_w, sel, we, cti, bte, cyc, stb,
        output dat_r, ack, err, rty
    );
endinterface

// File: rtl/wb_bus_timeout.sv
// Wishbone classic-cycle watchdog: forwards every request and, if no slave answers
// within TIMEOUT clocks, aborts the slave side and terminates the CPU cycle itself.
module wb_bus_timeout #(
    parameter int unsigned TIMEOUT        = 256,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF,
    parameter bit          ACK_ON_TIMEOUT = 1'b1
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    wb_bus_timeout_if.slave          wbs,
    wb_bus_timeout_if.master         wbm,
    output logic [31:0]              fault_adr_o,
    output logic                     fault_we_o,
    output logic [7:0]               fault_cnt_o,
    output logic                     irq_o,
    input  logic                     irq_clr_i
);

    typedef enum logic {
        ST_ACTIVE = 1'b0,
        ST_ABORT  = 1'b1
    } state_e;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] fault_adr_q, fault_adr_d;
    logic        fault_we_q, fault_we_d;
    logic [7:0]  fault_cnt_q, fault_cnt_d;
    logic        irq_q, irq_d;

    logic req;
    logic resp;

    assign req  = wbs.cyc & wbs.stb;
    assign resp = wbm.ack | wbm.err | wbm.rty;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fault_adr_d = fault_adr_q;
        fault_we_d  = fault_we_q;
        fault_cnt_d = fault_cnt_q;
        irq_d       = irq_q & ~irq_clr_i;

        wbm.adr   = wbs.adr;
        wbm.dat_w = wbs.dat_w;
        wbm.sel   = wbs.sel;
        wbm.we    = wbs.we;
        wbm.cti   = wbs.cti;
        wbm.bte   = wbs.bte;
        wbm.cyc   = wbs.cyc;
        wbm.stb   = wbs.stb;

        // Responses only pass while a request is open, so a late answer to an
        // already-aborted cycle cannot leak through to the CPU.
        wbs.dat_r = wbm.dat_r;
        wbs.ack   = wbm.ack & req;
        wbs.err   = wbm.err & req;
        wbs.rty   = wbm.rty & req;

        unique case (state_q)
            ST_ACTIVE: begin
                if (!req || resp) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ST_ABORT;
                    cnt_d       = '0;
                    fault_adr_d = wbs.adr;
                    fault_we_d  = wbs.we;
                    if (fault_cnt_q != 8'hFF) begin
                        fault_cnt_d = fault_cnt_q + 8'd1;
                    end
                    irq_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_ABORT: begin
                wbm.cyc   = 1'b0;
                wbm.stb   = 1'b0;
                wbs.ack   = ACK_ON_TIMEOUT;
                wbs.err   = ~ACK_ON_TIMEOUT;
                wbs.rty   = 1'b0;
                wbs.dat_r = ERR_DATA;
                state_d   = ST_ACTIVE;
                cnt_d     = '0;
            end
            default: begin
                state_d = ST_ACTIVE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_ACTIVE;
            cnt_q       <= '0;
            fault_adr_q <= '0;
            fault_we_q  <= 1'b0;
            fault_cnt_q <= '0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fault_adr_q <= fault_adr_d;
            fault_we_q  <= fault_we_d;
            fault_cnt_q <= fault_cnt_d;
            irq_q       <= irq_d;
        end
    end

    assign fault_adr_o = fault_adr_q;
    assign fault_we_o  = fault_we_q;
    assign fault_cnt_o = fault_cnt_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_wb_bus_timeout.sv
// Directed bench for wb_bus_timeout: one ack-on-timeout instance and one
// err-on-timeout instance, both with TIMEOUT = 16.
module tb_wb_bus_timeout;

    logic clk = 1'b0;
    logic rst;
    logic irq_clr1, irq_clr2;

    logic [31:0] fadr1, fadr2;
    logic        fwe1, fwe2;
    logic [7:0]  fcnt1, fcnt2;
    logic        irq1, irq2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_bus_timeout_if cpu1 ();
    wb_bus_timeout_if bus1 ();
    wb_bus_timeout_if cpu2 ();
    wb_bus_timeout_if bus2 ();

    wb_bus_timeout #(
        .TIMEOUT        (16),
        .ERR_DATA       (32'hDEAD_BEEF),
        .ACK_ON_TIMEOUT (1'b1)
    ) dut1 (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs         (cpu1),
        .wbm         (bus1),
        .fault_adr_o (fadr1),
        .fault_we_o  (fwe1),
        .fault_cnt_o (fcnt1),
        .irq_o       (irq1),
        .irq_clr_i   (irq_clr1)
    );

    wb_bus_timeout #(
        .TIMEOUT        (16),
        .ERR_DATA       (32'hDEAD_BEEF),
        .ACK_ON_TIMEOUT (1'b0)
    ) dut2 (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs         (cpu2),
        .wbm         (bus2),
        .fault_adr_o (fadr2),
        .fault_we_o  (fwe2),
        .fault_cnt_o (fcnt2),
        .irq_o       (irq2),
        .irq_clr_i   (irq_clr2)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle1();
        cpu1.cyc = 1'b0; cpu1.stb = 1'b0; cpu1.we = 1'b0; cpu1.adr = '0;
        cpu1.dat_w = '0; cpu1.sel = '0; cpu1.cti = '0; cpu1.bte = '0;
        bus1.ack = 1'b0; bus1.err = 1'b0; bus1.rty = 1'b0; bus1.dat_r = '0;
        irq_clr1 = 1'b0;
    endtask

    task automatic idle2();
        cpu2.cyc = 1'b0; cpu2.stb = 1'b0; cpu2.we = 1'b0; cpu2.adr = '0;
        cpu2.dat_w = '0; cpu2.sel = '0; cpu2.cti = '0; cpu2.bte = '0;
        bus2.ack = 1'b0; bus2.err = 1'b0; bus2.rty = 1'b0; bus2.dat_r = '0;
        irq_clr2 = 1'b0;
    endtask

    task automatic req1(input logic [31:0] adr, input logic we);
        cpu1.cyc = 1'b1; cpu1.stb = 1'b1; cpu1.adr = adr; cpu1.we = we; cpu1.sel = 4'hF;
    endtask

    task automatic req2(input logic [31:0] adr, input logic we);
        cpu2.cyc = 1'b1; cpu2.stb = 1'b1; cpu2.adr = adr; cpu2.we = we; cpu2.sel = 4'hF;
    endtask

    task automatic test_reset();
        idle1(); idle2();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        req1(32'hA5A5_0004, 1'b0);
        mid();
        total++;
        if ({fadr1, fwe1, fcnt1, irq1} !== 42'd0) begin
            bad++; $display("FAIL reset_fault: got adr=%h we=%b cnt=%0d irq=%b want all 0", fadr1, fwe1, fcnt1, irq1);
        end
        total++;
        if ({cpu1.ack, cpu1.err, cpu1.rty} !== 3'b000) begin
            bad++; $display("FAIL reset_resp: got ack/err/rty=%b want 000", {cpu1.ack, cpu1.err, cpu1.rty});
        end
        total++;
        if ({bus1.adr, bus1.cyc, bus1.stb} !== {32'hA5A5_0004, 2'b11}) begin
            bad++; $display("FAIL reset_passthru: got adr=%h cyc=%b stb=%b want a5a50004 1 1", bus1.adr, bus1.cyc, bus1.stb);
        end
        idle1();
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_normal_read();
        for (int c = 0; c <= 3; c++) begin
            req1(32'h1000_0000, 1'b0);
            if (c == 3) begin bus1.ack = 1'b1; bus1.dat_r = 32'h1234_5678; end
            mid();
            if (c == 0) begin
                total++;
                if ({bus1.adr, bus1.stb, cpu1.ack} !== {32'h1000_0000, 2'b10}) begin
                    bad++; $display("FAIL read_c0: got adr=%h stb=%b ack=%b want 10000000 1 0", bus1.adr, bus1.stb, cpu1.ack);
                end
            end
            if (c == 3) begin
                total++;
                if ({cpu1.ack, cpu1.dat_r} !== {1'b1, 32'h1234_5678}) begin
                    bad++; $display("FAIL read_ack: got ack=%b dat=%h want 1 12345678", cpu1.ack, cpu1.dat_r);
                end
            end
            next_cycle();
        end
        idle1();
        mid();
        total++;
        if ({fcnt1, irq1, cpu1.ack} !== 10'd0) begin
            bad++; $display("FAIL read_after: got cnt=%0d irq=%b ack=%b want 0 0 0", fcnt1, irq1, cpu1.ack);
        end
        next_cycle();
    endtask

    task automatic test_write_passthru();
        cpu1.cyc = 1'b1; cpu1.stb = 1'b1; cpu1.we = 1'b1; cpu1.adr = 32'h2000_0010;
        cpu1.dat_w = 32'hCAFE_F00D; cpu1.sel = 4'b0110; cpu1.cti = 3'b111; cpu1.bte = 2'b01;
        bus1.err = 1'b1;
        mid();
        total++;
        if ({bus1.adr, bus1.dat_w, bus1.sel, bus1.we, bus1.cti, bus1.bte, bus1.cyc, bus1.stb}
            !== {32'h2000_0010, 32'hCAFE_F00D, 4'b0110, 1'b1, 3'b111, 2'b01, 2'b11}) begin
            bad++; $display("FAIL write_fwd: got adr=%h dat=%h sel=%b we=%b cti=%b bte=%b want 20000010 cafef00d 0110 1 111 01",
                            bus1.adr, bus1.dat_w, bus1.sel, bus1.we, bus1.cti, bus1.bte);
        end
        total++;
        if ({cpu1.ack, cpu1.err, cpu1.rty} !== 3'b010) begin
            bad++; $display("FAIL write_err: got ack/err/rty=%b want 010", {cpu1.ack, cpu1.err, cpu1.rty});
        end
        next_cycle();
        idle1();
        next_cycle();
    endtask

    task automatic test_timeout_read();
        for (int c = 0; c <= 16; c++) begin
            req1(32'h9000_0000, 1'b0);
            if (c == 16) begin bus1.err = 1'b1; bus1.dat_r = 32'h1111_1111; end
            mid();
            if (c < 16) begin
                total++;
                if ({bus1.stb, cpu1.ack, cpu1.err} !== 3'b100) begin
                    bad++; $display("FAIL to_wait c=%0d: got stb/ack/err=%b want 100", c, {bus1.stb, cpu1.ack, cpu1.err});
                end
            end else begin
                total++;
                if ({bus1.cyc, bus1.stb, cpu1.ack, cpu1.err, cpu1.rty} !== 5'b00100) begin
                    bad++; $display("FAIL to_abort: got cyc/stb/ack/err/rty=%b want 00100", {bus1.cyc, bus1.stb, cpu1.ack, cpu1.err, cpu1.rty});
                end
                total++;
                if (cpu1.dat_r !== 32'hDEAD_BEEF) begin
                    bad++; $display("FAIL to_data: got %h want deadbeef", cpu1.dat_r);
                end
                total++;
                if ({fadr1, fwe1, fcnt1, irq1} !== {32'h9000_0000, 1'b0, 8'd1, 1'b1}) begin
                    bad++; $display("FAIL to_fault: got adr=%h we=%b cnt=%0d irq=%b want 90000000 0 1 1", fadr1, fwe1, fcnt1, irq1);
                end
            end
            next_cycle();
        end
        idle1();
        mid();
        total++;
        if ({cpu1.ack, cpu1.err, fcnt1} !== {2'b00, 8'd1}) begin
            bad++; $display("FAIL to_after: got ack=%b err=%b cnt=%0d want 0 0 1", cpu1.ack, cpu1.err, fcnt1);
        end
        next_cycle();
    endtask

    task automatic test_race();
        for (int c = 0; c <= 15; c++) begin
            req1(32'h9000_0100, 1'b0);
            if (c == 15) begin bus1.ack = 1'b1; bus1.dat_r = 32'h0BAD_F00D; end
            mid();
            if (c == 15) begin
                total++;
                if ({bus1.stb, cpu1.ack, cpu1.dat_r} !== {2'b11, 32'h0BAD_F00D}) begin
                    bad++; $display("FAIL race_ack: got stb=%b ack=%b dat=%h want 1 1 0badf00d", bus1.stb, cpu1.ack, cpu1.dat_r);
                end
            end
            next_cycle();
        end
        idle1();
        mid();
        total++;
        if ({cpu1.ack, cpu1.err, fcnt1} !== {2'b00, 8'd1}) begin
            bad++; $display("FAIL race_noabort: got ack=%b err=%b cnt=%0d want 0 0 1", cpu1.ack, cpu1.err, fcnt1);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c <= 22; c++) begin
            if (c <= 5) req1(32'h3000_0000, 1'b0);
            else        req1(32'h3000_0004, 1'b1);
            bus1.ack = (c == 5);
            mid();
            if (c == 21) begin
                total++;
                if ({bus1.stb, cpu1.ack} !== 2'b10) begin
                    bad++; $display("FAIL b2b_wait: got stb=%b ack=%b want 1 0", bus1.stb, cpu1.ack);
                end
            end
            if (c == 22) begin
                total++;
                if ({bus1.stb, cpu1.ack, fadr1, fwe1, fcnt1} !== {2'b01, 32'h3000_0004, 1'b1, 8'd2}) begin
                    bad++; $display("FAIL b2b_abort: got stb=%b ack=%b adr=%h we=%b cnt=%0d want 0 1 30000004 1 2",
                                    bus1.stb, cpu1.ack, fadr1, fwe1, fcnt1);
                end
            end
            next_cycle();
        end
        idle1();
        next_cycle();
    endtask

    task automatic test_saturation();
        int bad_lat = 0;
        for (int n = 0; n < 300; n++) begin
            int lat = 0;
            req1(32'h4000_0000 + 32'(n * 4), 1'b1);
            while (lat < 40) begin
                mid();
                if (cpu1.ack === 1'b1) break;
                next_cycle();
                lat++;
            end
            if (lat != 16) bad_lat++;
            next_cycle();
            idle1();
            next_cycle();
        end
        total++;
        if (bad_lat !== 0) begin
            bad++; $display("FAIL sat_latency: got %0d aborts off 16 cycles want 0", bad_lat);
        end
        mid();
        total++;
        if ({fadr1, fwe1, fcnt1, irq1} !== {32'h4000_04AC, 1'b1, 8'd255, 1'b1}) begin
            bad++; $display("FAIL sat_fault: got adr=%h we=%b cnt=%0d irq=%b want 400004ac 1 255 1", fadr1, fwe1, fcnt1, irq1);
        end
        next_cycle();
    endtask

    task automatic test_irq_clear();
        irq_clr1 = 1'b1;
        mid();
        total++;
        if (irq1 !== 1'b1) begin
            bad++; $display("FAIL irqclr_same: got %b want 1", irq1);
        end
        next_cycle();
        irq_clr1 = 1'b0;
        mid();
        total++;
        if ({irq1, fcnt1, fwe1} !== {1'b0, 8'd255, 1'b1}) begin
            bad++; $display("FAIL irqclr_next: got irq=%b cnt=%0d we=%b want 0 255 1", irq1, fcnt1, fwe1);
        end
        next_cycle();
    endtask

    task automatic test_irq_set_wins();
        for (int c = 0; c <= 16; c++) begin
            req1(32'h7000_0000, 1'b0);
            irq_clr1 = (c == 15);
            mid();
            if (c == 15) begin
                total++;
                if (irq1 !== 1'b0) begin
                    bad++; $display("FAIL setwins_pre: got irq=%b want 0", irq1);
                end
            end
            if (c == 16) begin
                total++;
                if ({cpu1.ack, irq1, fcnt1, fadr1} !== {2'b11, 8'd255, 32'h7000_0000}) begin
                    bad++; $display("FAIL setwins: got ack=%b irq=%b cnt=%0d adr=%h want 1 1 255 70000000",
                                    cpu1.ack, irq1, fcnt1, fadr1);
                end
            end
            next_cycle();
        end
        idle1();
        next_cycle();
    endtask

    task automatic test_error_mode();
        for (int c = 0; c <= 16; c++) begin
            req2(32'h8000_0000, 1'b0);
            mid();
            if (c == 15) begin
                total++;
                if ({cpu2.ack, cpu2.err} !== 2'b00) begin
                    bad++; $display("FAIL err_wait: got ack=%b err=%b want 0 0", cpu2.ack, cpu2.err);
                end
            end
            if (c == 16) begin
                total++;
                if ({cpu2.ack, cpu2.err, cpu2.rty, cpu2.dat_r, fcnt2, irq2} !== {3'b010, 32'hDEAD_BEEF, 8'd1, 1'b1}) begin
                    bad++; $display("FAIL err_abort: got ack=%b err=%b rty=%b dat=%h cnt=%0d irq=%b want 0 1 0 deadbeef 1 1",
                                    cpu2.ack, cpu2.err, cpu2.rty, cpu2.dat_r, fcnt2, irq2);
                end
            end
            next_cycle();
        end
        idle2();
        mid();
        total++;
        if (cpu2.err !== 1'b0) begin
            bad++; $display("FAIL err_single: got err=%b want 0", cpu2.err);
        end
        next_cycle();
        for (int c = 0; c <= 27; c++) begin
            req2(32'h8000_0040, 1'b1);
            bus2.rty = (c == 10);
            mid();
            if (c == 10) begin
                total++;
                if ({cpu2.rty, cpu2.err, cpu2.ack} !== 3'b100) begin
                    bad++; $display("FAIL rty_fwd: got rty/err/ack=%b want 100", {cpu2.rty, cpu2.err, cpu2.ack});
                end
            end
            if (c == 26) begin
                total++;
                if (cpu2.err !== 1'b0) begin
                    bad++; $display("FAIL rty_restart: got err=%b want 0", cpu2.err);
                end
            end
            if (c == 27) begin
                total++;
                if ({cpu2.err, fcnt2, fwe2} !== {1'b1, 8'd2, 1'b1}) begin
                    bad++; $display("FAIL rty_abort: got err=%b cnt=%0d we=%b want 1 2 1", cpu2.err, fcnt2, fwe2);
                end
            end
            next_cycle();
        end
        idle2();
        next_cycle();
    endtask

    task automatic test_reset_mid_count();
        for (int c = 0; c <= 28; c++) begin
            req1(32'h5000_0000, 1'b0);
            rst = (c == 10 || c == 11);
            mid();
            if (c == 10) begin
                total++;
                if (fcnt1 !== 8'd255) begin
                    bad++; $display("FAIL rstmid_sync: got cnt=%0d want 255", fcnt1);
                end
            end
            if (c == 11) begin
                total++;
                if ({fadr1, fwe1, fcnt1, irq1, cpu1.ack, bus1.stb} !== {42'd0, 2'b01}) begin
                    bad++; $display("FAIL rstmid_zero: got adr=%h we=%b cnt=%0d irq=%b ack=%b stb=%b want 0 0 0 0 0 1",
                                    fadr1, fwe1, fcnt1, irq1, cpu1.ack, bus1.stb);
                end
            end
            if (c == 27) begin
                total++;
                if (cpu1.ack !== 1'b0) begin
                    bad++; $display("FAIL rstmid_wait: got ack=%b want 0", cpu1.ack);
                end
            end
            if (c == 28) begin
                total++;
                if ({cpu1.ack, fcnt1, fadr1, irq1} !== {1'b1, 8'd1, 32'h5000_0000, 1'b1}) begin
                    bad++; $display("FAIL rstmid_abort: got ack=%b cnt=%0d adr=%h irq=%b want 1 1 50000000 1",
                                    cpu1.ack, fcnt1, fadr1, irq1);
                end
            end
            next_cycle();
        end
        idle1();
        next_cycle();
    endtask

    task automatic test_reset_during_abort();
        for (int c = 0; c <= 17; c++) begin
            req1(32'h6000_0000, 1'b0);
            rst = (c >= 16);
            mid();
            if (c == 16) begin
                total++;
                if (cpu1.ack !== 1'b1) begin
                    bad++; $display("FAIL rstabort_cur: got ack=%b want 1", cpu1.ack);
                end
            end
            if (c == 17) begin
                total++;
                if ({cpu1.ack, cpu1.err, bus1.stb, fcnt1} !== {3'b001, 8'd0}) begin
                    bad++; $display("FAIL rstabort_next: got ack=%b err=%b stb=%b cnt=%0d want 0 0 1 0",
                                    cpu1.ack, cpu1.err, bus1.stb, fcnt1);
                end
            end
            next_cycle();
        end
        rst = 1'b0;
        idle1();
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_normal_read();
        test_write_passthru();
        test_timeout_read();
        test_race();
        test_back_to_back();
        test_saturation();
        test_irq_clear();
        test_irq_set_wins();
        test_error_mode();
        test_reset_mid_count();
        test_reset_during_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_bus_timeout.md
# wb_bus_timeout

Wishbone B3 classic-cycle bus watchdog placed directly downstream of the `picorv32_wb` master port and upstream of the interconnect master port. It forwards every request unchanged. If no slave terminates a cycle within `TIMEOUT` clocks, it aborts the slave side and completes the cycle toward the CPU with a fixed data word, so that an unmapped address or a hung slave (e.g. SDRAM before init) cannot stall the core forever. Each abort is logged in fault registers and raises a sticky interrupt.

## Interface
- `TIMEOUT`, 256: clocks without a response before abort; legal range 2..65535.
- `ERR_DATA`, 32'hDEAD_BEEF: read data returned to the CPU on abort.
- `ACK_ON_TIMEOUT`, 1: 1 = terminate the CPU cycle with `wbs_ack_o`; 0 = terminate with `wbs_err_o`.
- `wb_clk_i`  in  1  system clock.
- `wb_rst_i`  in  1  synchronous, active-high reset.
- `wbs_adr_i` / `wbm_adr_o`  in/out  32  address, forwarded.
- `wbs_dat_i` / `wbm_dat_o`  in/out  32  write data, forwarded.
- `wbs_sel_i` / `wbm_sel_o`  in/out  4  byte selects, forwarded.
- `wbs_we_i` / `wbm_we_o`  in/out  1  write enable, forwarded.
- `wbs_cti_i` / `wbm_cti_o`, `wbs_bte_i` / `wbm_bte_o`  in/out  3/2  forwarded.
- `wbs_cyc_i` / `wbm_cyc_o`, `wbs_stb_i` / `wbm_stb_o`  in/out  1  forwarded, gated during ABORT.
- `wbm_dat_i` / `wbs_dat_o`  in/out  32  read data; `ERR_DATA` during ABORT.
- `wbm_ack_i`, `wbm_err_i`, `wbm_rty_i`  in  1  slave responses.
- `wbs_ack_o`, `wbs_err_o`, `wbs_rty_o`  out  1  responses to the CPU.
- `fault_adr_o`  out  32  address of the most recent aborted cycle.
- `fault_we_o`  out  1  `we` of the most recent aborted cycle.
- `fault_cnt_o`  out  8  number of aborts, saturating.
- `irq_o`  out  1  sticky fault interrupt.
- `irq_clr_i`  in  1  clears `irq_o`.

## Operation
- `req = wbs_cyc_i & wbs_stb_i`
- `resp = wbm_ack_i | wbm_err_i | wbm_rty_i`

**State machine (2 states: ACTIVE, ABORT)**
- **ACTIVE**
  - All m2s signals pass combinationally; all s2m signals pass combinationally.
  - `cnt` (16 bit):
    - `cnt <= 0` when `!req` or `resp`.
    - Otherwise `cnt <= cnt+1`.
  - When `req & !resp & cnt == TIMEOUT-1`: go to ABORT and load the fault registers.
    - `fault_adr <= wbs_adr_i`, `fault_we <= wbs_we_i`.
    - `fault_cnt <= fault_cnt+1` unless already 255.
    - `irq <= 1`.
- **ABORT** (exactly 1 cycle, then back to ACTIVE with `cnt = 0`)
  - `wbm_cyc_o = wbm_stb_o = 0`.
  - `wbs_ack_o = ACK_ON_TIMEOUT`, `wbs_err_o = !ACK_ON_TIMEOUT`, `wbs_rty_o = 0`, `wbs_dat_o = ERR_DATA`.
  - Slave responses arriving in this cycle are discarded.

**Boundary cases**
- Response in the same cycle that `cnt == TIMEOUT-1`: the response wins. No abort, no fault update, `cnt <= 0`.
- Back-to-back cycles: `cnt` restarts from 0 for each new `req` after termination.
- `irq_clr_i` together with a new fault in the same cycle: `irq_o` stays 1 (set wins).
- `irq_clr_i` never affects `fault_*`.

**Reset**
- Reset value of every output is 0, except the pass-through outputs, which follow their inputs.
- On reset: state ACTIVE, `cnt = 0`, `fault_adr_o = 0`, `fault_we_o = 0`, `fault_cnt_o = 0`, `irq_o = 0`.
- Reset asserted during ABORT: the CPU-side response is suppressed from the following cycle onward.

## Timing
- Pass-through adds zero latency. Its only added logic is the ABORT gate on cyc/stb/ack/err/rty/dat.
- Abort latency: `req` first high in cycle 0 with no response → ABORT response in cycle `TIMEOUT` (counting from 0).
- The CPU-side strobe is seen high for `TIMEOUT+1` cycles in total.
- `fault_*` and `irq_o` update at the clock edge entering ABORT, so they are visible in the ABORT cycle itself.
- `irq_o` clears 1 cycle after `irq_clr_i`.
- A slave may not answer a cycle after it has been aborted. If `wbm_ack_i` arrives in the cycle after ABORT while `req` is low, it is ignored because it is passed only while `req` is high.

## Test plan
- **Normal read:** `TIMEOUT=16`, slave acks 3 cycles after stb with data 32'h1234_5678 → CPU gets ack in the same cycle with 32'h1234_5678; `fault_cnt_o = 0`, `irq_o = 0`.
- **Timeout read:** stb to address 32'h9000_0000, slave silent → `wbm_stb_o` low and `wbs_ack_o=1` with `wbs_dat_o=32'hDEAD_BEEF` exactly in cycle 16.
  - Then `fault_adr_o=32'h9000_0000`, `fault_we_o=0`, `fault_cnt_o=1`, `irq_o=1`.
- **Race:** slave acks in cycle 15 (the `cnt == TIMEOUT-1` cycle) → normal ack, no abort, `fault_cnt_o` unchanged.
- **Saturation and IRQ:** 300 consecutive timed-out writes → `fault_cnt_o = 255`, `fault_we_o = 1`.
  - Pulse `irq_clr_i` alone → `irq_o` drops next cycle.
  - Pulse `irq_clr_i` in the same cycle as a new fault → `irq_o` stays 1.
- **Error mode:** `ACK_ON_TIMEOUT=0` → timeout yields `wbs_err_o=1` for 1 cycle with `wbs_ack_o=0`.
  - Slave `wbm_rty_i` is forwarded unchanged and resets `cnt`.
- **Reset mid-count:** assert `wb_rst_i` at cycle 10 of a silent cycle, release, keep stb high → abort occurs 16 cycles after release, and all fault outputs were 0 during reset.
